pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_buffer.sv | 149 ++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Writeback trace capture: wrap/pre-trigger (mode 0) or fill-from-trigger (mode 1) into a DEPTH-entry ring.
// Pop data appears 1 cycle after an accepted rd_en; no backpressure, samples outside ARMED/POST are dropped.
module pipe_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              arm,
    input  logic              mode,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [AW:0]       post_cnt,
    input  logic              cap_valid,
    input  logic [PC_W-1:0]   cap_pc,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [TAG_W-1:0]  cap_tag,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [PC_W-1:0]   rd_pc,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [AW:0]       count,
    output logic [1:0]        state,
    output logic              triggered,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } st_t;

    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_MAX  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    st_t              st_q;
    logic             mode_q;
    logic [PC_W-1:0]  trig_q;
    logic [AW:0]      post_left;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];

    logic sample;
    logic hit;
    logic wr;
    logic wr_en;
    logic full;
    logic pop;

    always_comb begin
        sample = cap_valid && (st_q == ARMED || st_q == POST);
        hit    = sample && (st_q == ARMED) && (cap_pc == trig_q);
        // mode 1 only stores the trigger and what follows it
        wr     = sample && (!mode_q || st_q == POST || hit);
        wr_en  = wr && !arm && !RST;
        full   = (cnt == FULL);
        pop    = (st_q == DONE) && rd_en && (cnt != '0);
    end

    // storage is never reset; only counted entries are ever read out
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_pc[wptr]   <= cap_pc;
            mem_data[wptr] <= cap_data;
            mem_tag[wptr]  <= cap_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q      <= IDLE;
            mode_q    <= 1'b0;
            trig_q    <= '0;
            post_left <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rd_valid  <= 1'b0;
            rd_pc     <= '0;
            rd_data   <= '0;
            rd_tag    <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else if (arm) begin
            st_q      <= ARMED;
            mode_q    <= mode;
            trig_q    <= trig_pc;
            post_left <= (post_cnt > POST_MAX) ? POST_MAX : post_cnt;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rd_valid  <= 1'b0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_pc   <= mem_pc[rptr];
                rd_data <= mem_data[rptr];
                rd_tag  <= mem_tag[rptr];
                rptr    <= rptr + PTR_ONE;
                cnt     <= cnt - CNT_ONE;
            end

            if (wr) begin
                wptr <= wptr + PTR_ONE;
                if (!mode_q && full) begin
                    rptr     <= rptr + PTR_ONE;
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end

            if (hit) begin
                triggered <= 1'b1;
                if (mode_q || post_left != '0)
                    st_q <= POST;
                else
                    st_q <= DONE;
            end else if (wr && st_q == POST) begin
                if (mode_q) begin
                    if (cnt == FULL - CNT_ONE)
                        st_q <= DONE;
                end else begin
                    post_left <= post_left - CNT_ONE;
                    if (post_left == CNT_ONE)
                        st_q <= DONE;
                end
            end
        end
    end

    assign state = st_q;
    assign count = cnt;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer at DEPTH=8: capture modes, trigger edge cases, readout, reset.
module tb_pipe_trace_buffer;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              arm;
    logic              mode;
    logic [PC_W-1:0]   trig_pc;
    logic [AW:0]       post_cnt;
    logic              cap_valid;
    logic [PC_W-1:0]   cap_pc;
    logic [DATA_W-1:0] cap_data;
    logic [TAG_W-1:0]  cap_tag;
    logic              rd_en;
    logic              rd_valid;
    logic [PC_W-1:0]   rd_pc;
    logic [DATA_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic [AW:0]       count;
    logic [1:0]        state;
    logic              triggered;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int pulses;

    pipe_trace_buffer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST), .arm(arm), .mode(mode), .trig_pc(trig_pc),
        .post_cnt(post_cnt), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_data(cap_data), .cap_tag(cap_tag), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_data(rd_data), .rd_tag(rd_tag),
        .count(count), .state(state), .triggered(triggered), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic m, input logic [PC_W-1:0] tp, input logic [AW:0] pc);
        arm = 1'b1; mode = m; trig_pc = tp; post_cnt = pc;
        tick();
        arm = 1'b0;
    endtask

    task automatic cap(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] d);
        cap_valid = 1'b1; cap_pc = pc; cap_data = d; cap_tag = d[TAG_W-1:0];
        tick();
        cap_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b1; arm = 1'b0; mode = 1'b0; trig_pc = '0; post_cnt = '0;
        cap_valid = 1'b0; cap_pc = '0; cap_data = '0; cap_tag = '0; rd_en = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_data", rd_data, 0);
        RST = 1'b0;

        // mode 0 wrap, trigger on sample 9, two post samples
        do_arm(1'b0, 32'h40, 4'd2);
        chk("m0_armed", state, 1);
        for (int i = 1; i <= 12; i++) begin
            cap((i == 9) ? 32'h40 : 32'h100 + 32'(i * 4), 32'(i));
            if (i == 8) begin
                chk("m0_full_count", count, 8);
                chk("m0_full_noovf", overflow, 0);
            end
            if (i == 9) begin
                chk("m0_trig_state", state, 2);
                chk("m0_trig_flag", triggered, 1);
                chk("m0_trig_ovf", overflow, 1);
            end
            if (i == 10) chk("m0_post_state", state, 2);
            if (i == 11) chk("m0_done_state", state, 3);
        end
        chk("m0_count", count, 8);
        chk("m0_overflow", overflow, 1);

        // hold rd_en for 10 cycles: exactly 8 pops, oldest (4) first
        pulses = 0;
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rd_valid) begin
                chk("m0_pop_data", rd_data, 32'(4 + pulses));
                chk("m0_pop_tag", rd_tag, 5'(4 + pulses));
                pulses++;
            end
        end
        rd_en = 1'b0;
        chk("m0_pulses", pulses, 8);
        chk("m0_drain_count", count, 0);
        chk("m0_drain_state", state, 3);
        chk("m0_hold_data", rd_data, 11);

        // mode 1: pre-trigger samples dropped, fill from trigger
        do_arm(1'b1, 32'h20, 4'd0);
        cap(32'h10, 32'h1);
        cap(32'h14, 32'h2);
        cap(32'h18, 32'h3);
        chk("m1_pre_count", count, 0);
        chk("m1_pre_state", state, 1);
        cap(32'h20, 32'hA);
        chk("m1_trig_state", state, 2);
        chk("m1_trig_count", count, 1);
        chk("m1_triggered", triggered, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("m1_post_pop_ignored", rd_valid, 0);
        chk("m1_post_pop_count", count, 1);
        for (int i = 0; i < 10; i++) begin
            cap(32'h24 + 32'(i * 4), 32'hB + 32'(i));
            if (i == 5) chk("m1_not_done", state, 2);
            if (i == 6) chk("m1_done", state, 3);
        end
        chk("m1_count", count, 8);
        chk("m1_overflow", overflow, 0);
        rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("m1_pop_valid", rd_valid, 1);
            chk("m1_pop_data", rd_data, 32'hA + 32'(k));
            chk("m1_pop_pc", rd_pc, (k == 0) ? 32'h20 : 32'h20 + 32'(k * 4));
        end
        rd_en = 1'b0;

        // mode 0, post_cnt 0, trigger on first sample
        do_arm(1'b0, 32'h80, 4'd0);
        cap(32'h80, 32'h55);
        chk("pc0_state", state, 3);
        chk("pc0_count", count, 1);
        rd_en = 1'b1;
        tick();
        chk("pc0_pop1_valid", rd_valid, 1);
        chk("pc0_pop1_data", rd_data, 32'h55);
        tick();
        rd_en = 1'b0;
        chk("pc0_pop2_valid", rd_valid, 0);
        chk("pc0_pop2_hold", rd_data, 32'h55);

        // arm wins over a simultaneous trigger-matching sample
        cap_valid = 1'b1; cap_pc = 32'h80; cap_data = 32'h77;
        do_arm(1'b0, 32'h80, 4'd0);
        cap_valid = 1'b0;
        chk("armcap_state", state, 1);
        chk("armcap_count", count, 0);
        chk("armcap_trig", triggered, 0);

        // post_cnt above DEPTH-1 behaves as DEPTH-1
        do_arm(1'b0, 32'h80, 4'd15);
        cap(32'h80, 32'h1);
        for (int i = 0; i < 7; i++) begin
            cap(32'h200, 32'h2 + 32'(i));
            if (i == 5) chk("clamp_not_done", state, 2);
        end
        chk("clamp_done", state, 3);
        chk("clamp_count", count, 8);
        chk("clamp_ovf", overflow, 0);

        // reset mid-POST with five entries
        do_arm(1'b0, 32'h30, 4'd10);
        cap(32'h30, 32'h1);
        for (int i = 0; i < 4; i++) cap(32'h300, 32'h2 + 32'(i));
        chk("rstpost_count_pre", count, 5);
        chk("rstpost_state_pre", state, 2);
        RST = 1'b1;
        arm = 1'b1;
        tick();
        RST = 1'b0;
        arm = 1'b0;
        chk("rstpost_state", state, 0);
        chk("rstpost_count", count, 0);
        chk("rstpost_trig", triggered, 0);
        chk("rstpost_rd_data", rd_data, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rstpost_rd_ignored", rd_valid, 0);
        chk("rstpost_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
